// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle control FSM: state codes, opcodes,
// funct codes and the datapath select/control encodings.
package cpu_ctrl_pkg;

  typedef logic [5:0] state_t;

  localparam state_t ST_RESET   = 6'd0;
  localparam state_t ST_FETCH0  = 6'd1;
  localparam state_t ST_FETCH1  = 6'd2;
  localparam state_t ST_FETCH2  = 6'd3;
  localparam state_t ST_DECODE  = 6'd4;
  localparam state_t ST_R_EXEC  = 6'd5;
  localparam state_t ST_R_WB    = 6'd6;
  localparam state_t ST_SH_LOAD = 6'd7;
  localparam state_t ST_SH_OP   = 6'd8;
  localparam state_t ST_SH_WB   = 6'd9;
  localparam state_t ST_JR      = 6'd10;
  localparam state_t ST_I_EXEC  = 6'd11;
  localparam state_t ST_I_WB    = 6'd12;
  localparam state_t ST_ADDR    = 6'd13;
  localparam state_t ST_MEM0    = 6'd14;
  localparam state_t ST_MEM1    = 6'd15;
  localparam state_t ST_MEM2    = 6'd16;
  localparam state_t ST_LW_WB   = 6'd17;
  localparam state_t ST_SW_WR   = 6'd18;
  localparam state_t ST_BR      = 6'd19;
  localparam state_t ST_JUMP    = 6'd20;
  localparam state_t ST_LUI     = 6'd21;
  localparam state_t ST_EXC0    = 6'd22;
  localparam state_t ST_EXC1    = 6'd23;
  localparam state_t ST_EXC2    = 6'd24;
  localparam state_t ST_EXC3    = 6'd25;
  localparam state_t ST_EXC4    = 6'd26;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_CMP  = 3'b111;

  localparam logic [2:0] SH_HOLD = 3'b000;
  localparam logic [2:0] SH_LOAD = 3'b001;
  localparam logic [2:0] SH_SLL  = 3'b010;
  localparam logic [2:0] SH_SRL  = 3'b011;
  localparam logic [2:0] SH_SRA  = 3'b100;

  localparam logic [3:0] SRCB_B       = 4'd0;
  localparam logic [3:0] SRCB_FOUR    = 4'd1;
  localparam logic [3:0] SRCB_SEXT    = 4'd2;
  localparam logic [3:0] SRCB_SEXT_S2 = 4'd3;

  localparam logic [3:0] PCS_ALU    = 4'd0;
  localparam logic [3:0] PCS_ALUOUT = 4'd1;
  localparam logic [3:0] PCS_JUMP   = 4'd2;
  localparam logic [3:0] PCS_MDR    = 4'd4;

  localparam logic [3:0] WS_ALUOUT = 4'd0;
  localparam logic [3:0] WS_SHIFT  = 4'd1;
  localparam logic [3:0] WS_LUI    = 4'd2;

  localparam logic [1:0] EXC_NONE    = 2'b00;
  localparam logic [1:0] EXC_ILLEGAL = 2'b01;
  localparam logic [1:0] EXC_OVF     = 2'b10;

  function automatic logic [2:0] alu_for_funct(input logic [5:0] funct);
    case (funct)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/control_unit.sv
// Multicycle control FSM: registered state, dispatch on OPCODE/FUNCT and a
// combinational decode of every datapath control from the current state.
//   state            | meaning
//   RESET            | idle under reset
//   FETCH0..2        | PC+4, memory wait, IR/PC load
//   DECODE           | branch target into ALUout, dispatch
//   R_*, SH_*, I_*   | R-type, shift and addi execute/writeback
//   ADDR, MEM*, SW_WR| load/store address, read, writeback, write
//   BR, JUMP, JR, LUI| single-cycle terminal states
//   EXC0..4          | EPC save, vector fetch, PC redirect
module control_unit
  import cpu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OPCODE,
  input  logic [5:0] FUNCT,
  input  logic       Overflow,
  input  logic       Zero,
  input  logic       Igual,
  output logic       PCwrite,
  output logic       MemWrite,
  output logic       MemRead,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       EPCWrite,
  output logic       IorD,
  output logic       MemToReg,
  output logic       RegDest,
  output logic       AluSrcA,
  output logic [3:0] AluSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] ShiftControl,
  output logic [3:0] PCSource,
  output logic [3:0] WriteSrc,
  output logic [1:0] Exception,
  output logic [5:0] state_out
);

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_exc_code;
  logic [1:0] w_exc_code;
  logic       w_is_addsub;
  logic       w_br_taken;
  logic       w_unused_zero;

  assign w_unused_zero = Zero;
  assign w_is_addsub   = (FUNCT == FN_ADD) || (FUNCT == FN_SUB);
  assign w_br_taken    = (OPCODE == OP_BEQ) ? Igual : ~Igual;
  assign state_out     = r_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_RESET;
      r_exc_code <= EXC_NONE;
    end else begin
      r_state <= w_next;
      if (w_next == ST_EXC0) r_exc_code <= w_exc_code;
    end
  end

  always_comb begin
    w_next     = ST_FETCH0;
    w_exc_code = EXC_ILLEGAL;
    case (r_state)
      ST_FETCH0:  w_next = ST_FETCH1;
      ST_FETCH1:  w_next = ST_FETCH2;
      ST_FETCH2:  w_next = ST_DECODE;
      ST_DECODE: begin
        w_next = ST_EXC0;
        case (OPCODE)
          OP_RTYPE: begin
            case (FUNCT)
              FN_ADD, FN_SUB, FN_AND: w_next = ST_R_EXEC;
              FN_SLL, FN_SRL, FN_SRA: w_next = ST_SH_LOAD;
              FN_JR:                  w_next = ST_JR;
              default:                w_next = ST_EXC0;
            endcase
          end
          OP_ADDI:       w_next = ST_I_EXEC;
          OP_LW, OP_SW:  w_next = ST_ADDR;
          OP_BEQ, OP_BNE: w_next = ST_BR;
          OP_J:          w_next = ST_JUMP;
          OP_LUI:        w_next = ST_LUI;
          default:       w_next = ST_EXC0;
        endcase
      end
      // Overflow only matters for add/sub in R_EXEC and for addi.
      ST_R_EXEC: begin
        w_exc_code = EXC_OVF;
        w_next     = (Overflow && w_is_addsub) ? ST_EXC0 : ST_R_WB;
      end
      ST_I_EXEC: begin
        w_exc_code = EXC_OVF;
        w_next     = Overflow ? ST_EXC0 : ST_I_WB;
      end
      ST_SH_LOAD: w_next = ST_SH_OP;
      ST_SH_OP:   w_next = ST_SH_WB;
      ST_ADDR:    w_next = (OPCODE == OP_LW) ? ST_MEM0 : ST_SW_WR;
      ST_MEM0:    w_next = ST_MEM1;
      ST_MEM1:    w_next = ST_MEM2;
      ST_MEM2:    w_next = ST_LW_WB;
      ST_EXC0:    w_next = ST_EXC1;
      ST_EXC1:    w_next = ST_EXC2;
      ST_EXC2:    w_next = ST_EXC3;
      ST_EXC3:    w_next = ST_EXC4;
      default:    w_next = ST_FETCH0;
    endcase
  end

  // Reset gates the whole decode so no enable can fire in the reset cycle.
  always_comb begin
    PCwrite      = 1'b0;
    MemWrite     = 1'b0;
    MemRead      = 1'b0;
    IRWrite      = 1'b0;
    RegWrite     = 1'b0;
    EPCWrite     = 1'b0;
    IorD         = 1'b0;
    MemToReg     = 1'b0;
    RegDest      = 1'b0;
    AluSrcA      = 1'b0;
    AluSrcB      = SRCB_B;
    ALUControl   = ALU_PASS;
    ShiftControl = SH_HOLD;
    PCSource     = PCS_ALU;
    WriteSrc     = WS_ALUOUT;
    Exception    = EXC_NONE;
    if (!reset) begin
      case (r_state)
        ST_FETCH0, ST_FETCH1: begin
          AluSrcB    = SRCB_FOUR;
          ALUControl = ALU_ADD;
        end
        // PC+4 is still on the ALU result when PC loads from it.
        ST_FETCH2: begin
          AluSrcB    = SRCB_FOUR;
          ALUControl = ALU_ADD;
          IRWrite    = 1'b1;
          PCwrite    = 1'b1;
        end
        ST_DECODE: begin
          AluSrcB    = SRCB_SEXT_S2;
          ALUControl = ALU_ADD;
        end
        ST_R_EXEC: begin
          AluSrcA    = 1'b1;
          ALUControl = alu_for_funct(FUNCT);
        end
        ST_R_WB: begin
          RegDest  = 1'b1;
          RegWrite = 1'b1;
        end
        ST_SH_LOAD: ShiftControl = SH_LOAD;
        ST_SH_OP: begin
          case (FUNCT)
            FN_SRL:  ShiftControl = SH_SRL;
            FN_SRA:  ShiftControl = SH_SRA;
            default: ShiftControl = SH_SLL;
          endcase
        end
        ST_SH_WB: begin
          WriteSrc = WS_SHIFT;
          RegDest  = 1'b1;
          RegWrite = 1'b1;
        end
        ST_JR: begin
          AluSrcA = 1'b1;
          PCwrite = 1'b1;
        end
        ST_I_EXEC, ST_ADDR: begin
          AluSrcA    = 1'b1;
          AluSrcB    = SRCB_SEXT;
          ALUControl = ALU_ADD;
        end
        ST_I_WB:  RegWrite = 1'b1;
        ST_MEM0:  IorD = 1'b1;
        ST_MEM2:  MemRead = 1'b1;
        ST_LW_WB: begin
          MemToReg = 1'b1;
          RegWrite = 1'b1;
        end
        ST_SW_WR: begin
          IorD     = 1'b1;
          MemWrite = 1'b1;
        end
        ST_BR: begin
          AluSrcA    = 1'b1;
          ALUControl = ALU_SUB;
          PCwrite    = w_br_taken;
          PCSource   = w_br_taken ? PCS_ALUOUT : PCS_ALU;
        end
        ST_JUMP: begin
          PCSource = PCS_JUMP;
          PCwrite  = 1'b1;
        end
        ST_LUI: begin
          WriteSrc = WS_LUI;
          RegWrite = 1'b1;
        end
        ST_EXC0: begin
          AluSrcB    = SRCB_FOUR;
          ALUControl = ALU_SUB;
        end
        ST_EXC1: begin
          EPCWrite  = 1'b1;
          IorD      = 1'b1;
          Exception = r_exc_code;
        end
        ST_EXC2: begin
          IorD      = 1'b1;
          Exception = r_exc_code;
        end
        ST_EXC3: MemRead = 1'b1;
        ST_EXC4: begin
          PCSource = PCS_MDR;
          PCwrite  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: table of per-cycle expectations
// routed through a scoreboard queue, plus reset corner-case sequences.
module tb_control_unit;
  import cpu_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] OPCODE, FUNCT;
  logic       Overflow, Zero, Igual;
  logic       PCwrite, MemWrite, MemRead, IRWrite, RegWrite, EPCWrite;
  logic       IorD, MemToReg, RegDest, AluSrcA;
  logic [3:0] AluSrcB, PCSource, WriteSrc;
  logic [2:0] ALUControl, ShiftControl;
  logic [1:0] Exception;
  logic [5:0] state_out;

  control_unit dut (
    .clk(clk), .reset(reset), .OPCODE(OPCODE), .FUNCT(FUNCT),
    .Overflow(Overflow), .Zero(Zero), .Igual(Igual),
    .PCwrite(PCwrite), .MemWrite(MemWrite), .MemRead(MemRead),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .EPCWrite(EPCWrite),
    .IorD(IorD), .MemToReg(MemToReg), .RegDest(RegDest), .AluSrcA(AluSrcA),
    .AluSrcB(AluSrcB), .ALUControl(ALUControl), .ShiftControl(ShiftControl),
    .PCSource(PCSource), .WriteSrc(WriteSrc), .Exception(Exception),
    .state_out(state_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcw, mw, mr, irw, rw, epcw, iord, m2r, rdst, asa;
    logic [3:0] asb;
    logic [2:0] aluc, shc;
    logic [3:0] pcs, wsrc;
    logic [1:0] exc;
  } ctl_t;

  typedef struct {
    string      name;
    logic [5:0] op, fn;
    logic       ovf, ig;
    int         cyc;
    logic [5:0] st;
    ctl_t       ctl;
  } vec_t;

  ctl_t act;
  assign act = {PCwrite, MemWrite, MemRead, IRWrite, RegWrite, EPCWrite, IorD,
                MemToReg, RegDest, AluSrcA, AluSrcB, ALUControl, ShiftControl,
                PCSource, WriteSrc, Exception};

  int   checks = 0;
  int   failures = 0;
  vec_t tbl[$];
  vec_t sb[$];

  function automatic ctl_t mk(input logic pcw, mw, mr, irw, rw, epcw, iord,
                              m2r, rdst, asa, input logic [3:0] asb,
                              input logic [2:0] aluc, shc,
                              input logic [3:0] pcs, wsrc, input logic [1:0] exc);
    return {pcw, mw, mr, irw, rw, epcw, iord, m2r, rdst, asa, asb, aluc, shc,
            pcs, wsrc, exc};
  endfunction

  task automatic add(input string name, input logic [5:0] op, fn,
                     input logic ovf, ig, input int cyc, input logic [5:0] st,
                     input ctl_t ctl);
    vec_t v;
    v.name = name; v.op = op; v.fn = fn; v.ovf = ovf; v.ig = ig;
    v.cyc = cyc; v.st = st; v.ctl = ctl;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] got, exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Holds reset two edges, releases at a negedge; FETCH0 is cycle 1.
  task automatic start_instr(input logic [5:0] op, fn, input logic ovf, ig);
    @(negedge clk);
    reset = 1'b1; OPCODE = op; FUNCT = fn; Overflow = ovf; Igual = ig;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    vec_t e;
    start_instr(v.op, v.fn, v.ovf, v.ig);
    sb.push_back(v);
    repeat (v.cyc) @(posedge clk);
    @(negedge clk);
    if (sb.size() == 0) begin
      chk({v.name, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({e.name, "_state"}, {26'd0, state_out}, {26'd0, e.st});
      chk({e.name, "_ctl"}, {2'd0, act}, {2'd0, e.ctl});
    end
  endtask

  initial begin
    ctl_t z;
    ctl_t c_fetch, c_exc0;
    reset = 1'b1; OPCODE = '0; FUNCT = '0; Overflow = 1'b0; Zero = 1'b0; Igual = 1'b0;
    z       = '0;
    c_fetch = mk(0,0,0,0,0,0,0,0,0,0, 4'd1,3'd1,3'd0,4'd0,4'd0,2'd0);
    c_exc0  = mk(0,0,0,0,0,0,0,0,0,0, 4'd1,3'd2,3'd0,4'd0,4'd0,2'd0);

    add("add_fetch0", OP_RTYPE, FN_ADD, 0, 0, 1, ST_FETCH0, c_fetch);
    add("add_fetch1", OP_RTYPE, FN_ADD, 0, 0, 2, ST_FETCH1, c_fetch);
    add("add_fetch2", OP_RTYPE, FN_ADD, 0, 0, 3, ST_FETCH2,
        mk(1,0,0,1,0,0,0,0,0,0, 4'd1,3'd1,3'd0,4'd0,4'd0,2'd0));
    add("add_decode", OP_RTYPE, FN_ADD, 0, 0, 4, ST_DECODE,
        mk(0,0,0,0,0,0,0,0,0,0, 4'd3,3'd1,3'd0,4'd0,4'd0,2'd0));
    add("add_exec", OP_RTYPE, FN_ADD, 0, 0, 5, ST_R_EXEC,
        mk(0,0,0,0,0,0,0,0,0,1, 4'd0,3'd1,3'd0,4'd0,4'd0,2'd0));
    add("add_wb", OP_RTYPE, FN_ADD, 0, 0, 6, ST_R_WB,
        mk(0,0,0,0,1,0,0,0,1,0, 4'd0,3'd0,3'd0,4'd0,4'd0,2'd0));
    add("add_refetch", OP_RTYPE, FN_ADD, 0, 0, 7, ST_FETCH0, c_fetch);
    add("sub_exec", OP_RTYPE, FN_SUB, 0, 0, 5, ST_R_EXEC,
        mk(0,0,0,0,0,0,0,0,0,1, 4'd0,3'd2,3'd0,4'd0,4'd0,2'd0));
    add("and_exec", OP_RTYPE, FN_AND, 1, 0, 5, ST_R_EXEC,
        mk(0,0,0,0,0,0,0,0,0,1, 4'd0,3'd3,3'd0,4'd0,4'd0,2'd0));
    add("and_ovf_ignored", OP_RTYPE, FN_AND, 1, 0, 6, ST_R_WB,
        mk(0,0,0,0,1,0,0,0,1,0, 4'd0,3'd0,3'd0,4'd0,4'd0,2'd0));
    add("add_ovf_exc0", OP_RTYPE, FN_ADD, 1, 0, 6, ST_EXC0, c_exc0);
    add("add_ovf_exc1", OP_RTYPE, FN_ADD, 1, 0, 7, ST_EXC1,
        mk(0,0,0,0,0,1,1,0,0,0, 4'd0,3'd0,3'd0,4'd0,4'd0,2'd2));
    add("add_ovf_exc2", OP_RTYPE, FN_ADD, 1, 0, 8, ST_EXC2,
        mk(0,0,0,0,0,0,1,0,0,0, 4'd0,3'd0,3'd0,4'd0,4'd0,2'd2));
    add("add_ovf_exc3", OP_RTYPE, FN_ADD, 1, 0, 9, ST_EXC3,
        mk(0,0,1,0,0,0,0,0,0,0, 4'd0,3'd0,3'd0,4'd0,4'd0,2'd0));
    add("add_ovf_exc4", OP_RTYPE, FN_SUB, 1, 0, 10, ST_EXC4,
        mk(1,0,0,0,0,0,0,0,0,0, 4'd0,3'd0,3'd0,4'd4,4'd0,2'd0));
    add("beq_taken", OP_BEQ, 6'h00, 0, 1, 5, ST_BR,
        mk(1,0,0,0,0,0,0,0,0,1, 4'd0,3'd2,3'd0,4'd1,4'd0,2'd0));
    add("beq_not_taken", OP_BEQ, 6'h00, 0, 0, 5, ST_BR,
        mk(0,0,0,0,0,0,0,0,0,1, 4'd0,3'd2,3'd0,4'd0,4'd0,2'd0));
    add("bne_taken", OP_BNE, 6'h00, 0, 0, 5, ST_BR,
        mk(1,0,0,0,0,0,0,0,0,1, 4'd0,3'd2,3'd0,4'd1,4'd0,2'd0));
    add("bne_refetch", OP_BNE, 6'h00, 1, 1, 6, ST_FETCH0, c_fetch);
    add("lw_addr", OP_LW, 6'h00, 0, 0, 5, ST_ADDR,
        mk(0,0,0,0,0,0,0,0,0,1, 4'd2,3'd1,3'd0,4'd0,4'd0,2'd0));
    add("lw_mem0", OP_LW, 6'h00, 0, 0, 6, ST_MEM0,
        mk(0,0,0,0,0,0,1,0,0,0, 4'd0,3'd0,3'd0,4'd0,4'd0,2'd0));
    add("lw_mem2", OP_LW, 6'h00, 0, 0, 8, ST_MEM2,
        mk(0,0,1,0,0,0,0,0,0,0, 4'd0,3'd0,3'd0,4'd0,4'd0,2'd0));
    add("lw_wb", OP_LW, 6'h00, 0, 0, 9, ST_LW_WB,
        mk(0,0,0,0,1,0,0,1,0,0, 4'd0,3'd0,3'd0,4'd0,4'd0,2'd0));
    add("sw_wr", OP_SW, 6'h00, 0, 0, 6, ST_SW_WR,
        mk(0,1,0,0,0,0,1,0,0,0, 4'd0,3'd0,3'd0,4'd0,4'd0,2'd0));
    add("sw_refetch", OP_SW, 6'h00, 0, 0, 7, ST_FETCH0, c_fetch);
    add("sll_load", OP_RTYPE, FN_SLL, 0, 0, 5, ST_SH_LOAD,
        mk(0,0,0,0,0,0,0,0,0,0, 4'd0,3'd0,3'd1,4'd0,4'd0,2'd0));
    add("sll_op", OP_RTYPE, FN_SLL, 0, 0, 6, ST_SH_OP,
        mk(0,0,0,0,0,0,0,0,0,0, 4'd0,3'd0,3'd2,4'd0,4'd0,2'd0));
    add("srl_op", OP_RTYPE, FN_SRL, 0, 0, 6, ST_SH_OP,
        mk(0,0,0,0,0,0,0,0,0,0, 4'd0,3'd0,3'd3,4'd0,4'd0,2'd0));
    add("sra_op", OP_RTYPE, FN_SRA, 1, 0, 6, ST_SH_OP,
        mk(0,0,0,0,0,0,0,0,0,0, 4'd0,3'd0,3'd4,4'd0,4'd0,2'd0));
    add("sra_wb", OP_RTYPE, FN_SRA, 0, 0, 7, ST_SH_WB,
        mk(0,0,0,0,1,0,0,0,1,0, 4'd0,3'd0,3'd0,4'd0,4'd1,2'd0));
    add("j_jump", OP_J, 6'h00, 0, 0, 5, ST_JUMP,
        mk(1,0,0,0,0,0,0,0,0,0, 4'd0,3'd0,3'd0,4'd2,4'd0,2'd0));
    add("jr", OP_RTYPE, FN_JR, 0, 0, 5, ST_JR,
        mk(1,0,0,0,0,0,0,0,0,1, 4'd0,3'd0,3'd0,4'd0,4'd0,2'd0));
    add("addi_exec", OP_ADDI, 6'h00, 0, 0, 5, ST_I_EXEC,
        mk(0,0,0,0,0,0,0,0,0,1, 4'd2,3'd1,3'd0,4'd0,4'd0,2'd0));
    add("addi_wb", OP_ADDI, 6'h00, 0, 0, 6, ST_I_WB,
        mk(0,0,0,0,1,0,0,0,0,0, 4'd0,3'd0,3'd0,4'd0,4'd0,2'd0));
    add("addi_ovf_exc0", OP_ADDI, 6'h00, 1, 0, 6, ST_EXC0, c_exc0);
    add("addi_ovf_exc2", OP_ADDI, 6'h00, 1, 0, 8, ST_EXC2,
        mk(0,0,0,0,0,0,1,0,0,0, 4'd0,3'd0,3'd0,4'd0,4'd0,2'd2));
    add("lui", OP_LUI, 6'h00, 0, 0, 5, ST_LUI,
        mk(0,0,0,0,1,0,0,0,0,0, 4'd0,3'd0,3'd0,4'd0,4'd2,2'd0));
    add("illegal_op_exc0", 6'h3F, 6'h00, 0, 0, 5, ST_EXC0, c_exc0);
    add("illegal_op_exc1", 6'h3F, 6'h00, 0, 0, 6, ST_EXC1,
        mk(0,0,0,0,0,1,1,0,0,0, 4'd0,3'd0,3'd0,4'd0,4'd0,2'd1));
    add("illegal_fn_exc0", OP_RTYPE, 6'h3F, 0, 0, 5, ST_EXC0, c_exc0);
    add("illegal_fn_exc4", OP_RTYPE, 6'h3F, 0, 0, 9, ST_EXC4,
        mk(1,0,0,0,0,0,0,0,0,0, 4'd0,3'd0,3'd0,4'd4,4'd0,2'd0));

    // Reset held three cycles, then release and watch IRWrite.
    @(negedge clk);
    reset = 1'b1; OPCODE = OP_RTYPE; FUNCT = FN_ADD; Overflow = 1'b0;
    chk("reset_pre_edge_ctl", {2'd0, act}, {2'd0, z});
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      chk("reset_ctl", {2'd0, act}, {2'd0, z});
      chk("reset_state", {26'd0, state_out}, {26'd0, ST_RESET});
    end
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("release_fetch0", {26'd0, state_out}, {26'd0, ST_FETCH0});
    for (int c = 1; c <= 5; c++) begin
      chk($sformatf("irwrite_cycle%0d", c), {31'd0, IRWrite}, {31'd0, (c == 3)});
      @(posedge clk); @(negedge clk);
    end

    foreach (tbl[i]) run_vec(tbl[i]);

    // Illegal opcode, reset asserted while in EXC2.
    start_instr(6'h3F, 6'h00, 1'b0, 1'b0);
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("exc2_state", {26'd0, state_out}, {26'd0, ST_EXC2});
    chk("exc2_code", {30'd0, Exception}, 32'd1);
    reset = 1'b1;
    #1;
    chk("exc2_reset_ctl", {2'd0, act}, {2'd0, z});
    @(posedge clk); @(negedge clk);
    chk("exc2_reset_state", {26'd0, state_out}, {26'd0, ST_RESET});
    chk("exc2_reset_after_ctl", {2'd0, act}, {2'd0, z});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
